// File: rtl/nano_mem_sys.sv
// nano_mem_sys: 256x16 word store plus I/O window for NanoCPU, with a boot-time program loader.
// Latency: dataR is combinational from address; CPU writes and loader words land on the next rising edge.
// Backpressure: ld_ready is high only while loading (one word per cycle); the CPU bus is never stalled.
module nano_mem_sys #(
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [15:0] dataW,
  input  logic        ce,
  input  logic        we,
  output logic [15:0] dataR,
  output logic        cpu_rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  input  logic        ld_start,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out
);

  localparam logic [7:0] IO_GPO = IO_BASE;
  localparam logic [7:0] IO_GPI = IO_BASE + 8'd1;
  localparam logic [7:0] IO_CNT = IO_BASE + 8'd2;

  typedef enum logic [1:0] {ST_LOAD, ST_RELEASE, ST_RUN} state_t;

  state_t      state;
  logic [7:0]  ld_ptr;
  logic [15:0] cycle_cnt;
  logic [15:0] gpio_meta;
  logic [15:0] gpio_sync;
  logic [15:0] ram [256];

  logic ld_acc;
  logic cpu_wr;

  assign ld_acc = (state == ST_LOAD) && ld_valid;
  assign cpu_wr = (state == ST_RUN) && ce && we;

  // Sequencer: load -> one release cycle -> run; cpu_rst lags the state by one edge
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state    <= ST_LOAD;
      ld_ready <= 1'b1;
      cpu_rst  <= 1'b1;
      ld_ptr   <= 8'd0;
    end else begin
      cpu_rst <= (state != ST_RUN);
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            ld_ptr <= ld_ptr + 8'd1;
            // Leaving at 0xFF means the pointer never has to wrap inside a load
            if (ld_last || ld_ptr == 8'hFF) begin
              state    <= ST_RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (ld_start) begin
            state    <= ST_LOAD;
            ld_ready <= 1'b1;
            ld_ptr   <= 8'd0;
          end
        end
        default: begin
          state    <= ST_LOAD;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end

  // I/O registers: output port, free-running run-time counter, input synchronizer
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      gpio_out  <= 16'd0;
      cycle_cnt <= 16'd0;
      gpio_meta <= 16'd0;
      gpio_sync <= 16'd0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      if (cpu_wr && address == IO_GPO) begin
        gpio_out <= dataW;
      end
      if (state == ST_RUN) begin
        // A clear (software write or reload request) beats the increment
        if (ld_start || (cpu_wr && address == IO_CNT)) begin
          cycle_cnt <= 16'd0;
        end else begin
          cycle_cnt <= cycle_cnt + 16'd1;
        end
      end
    end
  end

  // Word store: loader and CPU writes never overlap because they live in different states
  always_ff @(posedge ck) begin
    if (ld_acc && ld_ptr < IO_BASE) begin
      ram[ld_ptr] <= ld_data;
    end else if (cpu_wr && address < IO_BASE) begin
      ram[address] <= dataW;
    end
  end

  // Read mux: the CPU sees zeros while a load is in progress
  always_comb begin
    dataR = 16'h0000;
    if (state != ST_LOAD) begin
      if (address < IO_BASE) begin
        dataR = ram[address];
      end else begin
        case (address)
          IO_GPO:  dataR = gpio_out;
          IO_GPI:  dataR = gpio_sync;
          IO_CNT:  dataR = cycle_cnt;
          default: dataR = 16'h0000;
        endcase
      end
    end
  end

endmodule
